// File: rtl/pcm_pwm_sink.sv
// PCM sample sink: small FIFO feeding an 8-bit PWM DAC.
// Each buffered sample plays for (rate+1) 256-clock PWM periods; an empty
// FIFO at a sample boundary keeps the last sample and raises a sticky flag.
module pcm_pwm_sink #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    pcm_in,
  input  logic                          pcm_in_vld,
  output logic                          pcm_in_rdy,
  input  logic [3:0]                    rate,
  input  logic                          underrun_clr,
  output logic                          pwm_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [3:0]                 rep_q, rep_d;
  logic [7:0]                 cur_sample_q, cur_sample_d;
  logic                       pwm_out_q, pwm_out_d;
  logic                       underrun_q, underrun_d;

  logic at_wrap, boundary, push, pop;

  // Ready depends only on occupancy, so a producer may wait on it safely.
  assign pcm_in_rdy = (level_q < LW'(FIFO_DEPTH));
  assign pwm_out    = pwm_out_q;
  assign underrun   = underrun_q;
  assign level      = level_q;

  // Next-state logic: PWM counter, repeat counter, FIFO and underrun flag.
  always_comb begin
    at_wrap  = (cnt_q == 8'hFF);
    // >= so a rate lowered below rep ends the sample at the next wrap.
    boundary = at_wrap && (rep_q >= rate);
    push     = pcm_in_vld && pcm_in_rdy;
    pop      = boundary && (level_q != '0);

    cnt_d = cnt_q + 8'd1;

    rep_d = rep_q;
    if (at_wrap) rep_d = boundary ? 4'd0 : rep_q + 4'd1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = pcm_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    rd_ptr_d     = rd_ptr_q;
    cur_sample_d = cur_sample_q;
    if (pop) begin
      // Only the old head is read, so a same-edge push never bypasses.
      cur_sample_d = mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end

    level_d = level_q + LW'(push) - LW'(pop);

    // A fresh underrun beats a simultaneous clear.
    if (boundary && (level_q == '0)) underrun_d = 1'b1;
    else if (underrun_clr)           underrun_d = 1'b0;
    else                             underrun_d = underrun_q;

    pwm_out_d = (cnt_q < cur_sample_q);
  end

  // State registers; reset restores midscale silence with an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      rep_q        <= '0;
      cur_sample_q <= 8'h80;
      pwm_out_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      rep_q        <= rep_d;
      cur_sample_q <= cur_sample_d;
      pwm_out_q    <= pwm_out_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcm_pwm_sink.sv
// Directed bench for pcm_pwm_sink: PWM duty per period reveals which
// sample is playing, so ordering and hold length are checked via high counts.
module tb_pcm_pwm_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pcm_in = '0;
  logic       pcm_in_vld = 1'b0;
  logic       pcm_in_rdy;
  logic [3:0] rate = '0;
  logic       underrun_clr = 1'b0;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] level;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] src [0:7];
  int n_src = 0;
  int idx = 0;
  int highs = 0;

  pcm_pwm_sink #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_in(pcm_in), .pcm_in_vld(pcm_in_vld),
    .pcm_in_rdy(pcm_in_rdy), .rate(rate), .underrun_clr(underrun_clr),
    .pwm_out(pwm_out), .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: producer offers src[idx] while any remain, count pwm highs.
  task automatic tick();
    logic acc;
    pcm_in     = (idx < n_src) ? src[idx] : 8'h00;
    pcm_in_vld = (idx < n_src);
    acc        = pcm_in_vld && pcm_in_rdy;
    @(posedge clk);
    #1;
    if (acc) idx++;
    if (pwm_out) highs++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pcm_in_vld = 1'b0;
    underrun_clr = 1'b0;
    idx = 0;
    n_src = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    highs = 0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rdy", 32'(pcm_in_rdy), 1);

    // Idle, rate 0: midscale duty, underrun at first boundary
    do_reset();
    rate = 4'd0;
    ticks(255);
    chk("idle_underrun_pre", 32'(underrun), 0);
    tick();
    chk("idle_highs_p0", highs, 128);
    chk("idle_underrun", 32'(underrun), 1);
    chk("idle_level", 32'(level), 0);
    highs = 0;
    ticks(256);
    chk("idle_highs_p1", highs, 128);

    // Single push of 0x40 on the first edge
    do_reset();
    src[0] = 8'h40; n_src = 1;
    tick();
    chk("one_level_e1", 32'(level), 1);
    ticks(254);
    chk("one_level_e255", 32'(level), 1);
    tick();
    chk("one_level_e256", 32'(level), 0);
    chk("one_underrun", 32'(underrun), 0);
    highs = 0;
    ticks(256);
    chk("one_highs_p1", highs, 64);

    // Back-pressure and ordering, 6 samples
    do_reset();
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    src[3] = 8'h44; src[4] = 8'h55; src[5] = 8'h66; n_src = 6;
    ticks(4);
    chk("bp_level_full", 32'(level), 4);
    chk("bp_rdy_full", 32'(pcm_in_rdy), 0);
    chk("bp_accepted", idx, 4);
    ticks(252);
    chk("bp_level_pop", 32'(level), 3);
    chk("bp_rdy_pop", 32'(pcm_in_rdy), 1);
    highs = 0;
    tick();
    chk("bp_level_refill", 32'(level), 4);
    ticks(255);
    chk("bp_highs_s0", highs, 32'h11);
    for (int p = 2; p <= 6; p++) begin
      highs = 0;
      ticks(256);
      chk($sformatf("bp_highs_s%0d", p - 1), highs, 32'(src[p-1]));
      if (p == 5) chk("bp_underrun_pre", 32'(underrun), 0);
    end
    chk("bp_underrun_end", 32'(underrun), 1);
    chk("bp_all_taken", idx, 6);
    chk("bp_level_end", 32'(level), 0);

    // Hold length with rate 3, then live rate change while rep == 2
    do_reset();
    rate = 4'd3;
    src[0] = 8'hA0; src[1] = 8'h30; src[2] = 8'h50;
    src[3] = 8'h70; src[4] = 8'h90; n_src = 5;
    ticks(1024);
    chk("r3_highs_reset_sample", highs, 512);
    highs = 0;
    ticks(1024);
    chk("r3_highs_a0", highs, 4 * 32'hA0);
    highs = 0;
    ticks(512);
    rate = 4'd0;
    ticks(256);
    chk("r3_highs_30_cut", highs, 3 * 32'h30);
    highs = 0;
    ticks(256);
    chk("r0_highs_50", highs, 32'h50);
    chk("r3_underrun", 32'(underrun), 0);

    // Underrun clear: honoured off-boundary, loses to a fresh underrun
    do_reset();
    rate = 4'd0;
    ticks(299);
    chk("clr_set", 32'(underrun), 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_nonboundary", 32'(underrun), 0);
    ticks(211);
    chk("clr_before_boundary", 32'(underrun), 0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_vs_underrun", 32'(underrun), 1);

    // Asynchronous reset mid-period with three buffered samples
    do_reset();
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; n_src = 3;
    ticks(100);
    chk("ar_level_pre", 32'(level), 3);
    chk("ar_pwm_pre", 32'(pwm_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 0);
    chk("ar_pwm", 32'(pwm_out), 0);
    chk("ar_underrun", 32'(underrun), 0);
    chk("ar_rdy", 32'(pcm_in_rdy), 1);
    pcm_in = 8'h77;
    pcm_in_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ar_discard", 32'(level), 0);
    pcm_in_vld = 1'b0;
    rst_n = 1'b1;
    idx = 0; n_src = 0; highs = 0;
    ticks(256);
    chk("ar_midscale", highs, 128);
    chk("ar_level_post", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
